issue_stage: RTL and testbench
==============================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL have parameter EVEN_NOP, default 32'h40200000, the instruction driven on an idle even pipe.
REQ-002 SHALL have parameter ODD_NOP, default 32'h00200000 (lnop), the instruction driven on an idle odd pipe.
REQ-003 SHALL have ports:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high
- inst_valid  in  1  fetch pair present
- pc_input  in  32 [0:31]  PC of first_inst
- first_inst  in  32 [0:31]  older instruction of the pair
- second_inst  in  32 [0:31]  younger instruction, PC = pc_input+4
- pipe_stall  in  1  downstream hazard hold
- flush  in  1  branch redirect, discard everything held
- stall  out  1  to fetch; fetch holds its outputs while high
- even_valid, odd_valid  out  1 each  pipe slot carries a real instruction
- even_inst, odd_inst  out  32 [0:31]  issued instruction per pipe
- even_pc, odd_pc  out  32 [0:31]  PC of issued instruction
- halted  out  1  stop instruction reached

Function
REQ-004 SHALL classify an instruction as odd-pipe when inst[0:1]==2'b00 and inst[0:10]!=11'b0, else even-pipe.
REQ-005 SHALL treat inst[0:10]==11'b00000000000 as STOP; STOP is never issued.
REQ-006 SHALL treat EVEN_NOP and ODD_NOP opcodes (inst[0:10]) as non-writing; all other issuable instructions write RT=inst[25:31].
REQ-007 SHALL detect a pair RAW hazard when first writes and second's RA=inst[18:24] or RB=inst[11:17] equals first's RT.
REQ-008 SHALL implement states ISSUE, SPLIT, HALT.
REQ-009 In ISSUE with inst_valid=1, pipe_stall=0, flush=0: pair dual-issues when classes differ and no RAW hazard; both pipe outputs register next posedge (latency 1), state stays ISSUE.
REQ-010 In ISSUE, if both same class or RAW hazard: first issues next posedge, second plus its PC are latched into the hold register, state -> SPLIT.
REQ-011 In SPLIT: held instruction issues on its pipe next posedge, other pipe idle, state -> ISSUE; inputs ignored.
REQ-012 stall SHALL be combinational = (state==SPLIT) | pipe_stall | (state==HALT).
REQ-013 If first is STOP: nothing issues, second discarded, state -> HALT.
REQ-014 If second is STOP and first is not: first issues alone, state -> HALT.
REQ-015 HALT SHALL be sticky until reset; halted=1, both valids 0.
REQ-016 pipe_stall=1 (flush=0) SHALL freeze state, hold register and all pipe outputs.
REQ-017 flush=1 SHALL, next posedge, clear valids, drop the hold register, go to ISSUE from ISSUE or SPLIT; flush over pipe_stall; HALT unaffected.
REQ-018 inst_valid=0 in ISSUE SHALL issue nothing (both valids 0).
REQ-019 Idle pipe SHALL drive its NOP parameter, valid 0, PC 0.
REQ-020 An instruction SHALL never issue twice nor be reordered after a younger one.

Reset
REQ-021 On reset assertion, asynchronously: state=ISSUE, hold register cleared, valids=0, even_inst=EVEN_NOP, odd_inst=ODD_NOP, PCs=0, halted=0.
REQ-022 Reset mid-SPLIT SHALL discard the held instruction; first posedge after release behaves as ISSUE.

Verification
REQ-023 Dual issue: pc=0x10, first=add (even, RT=5), second=lqd (odd, RA=7) -> next cycle even_pc=0x10, odd_pc=0x14, both valid, stall=0.
REQ-024 Structural split: two even adds at pc=0x20 -> cycle1 even_pc=0x20 only, stall=1; cycle2 even_pc=0x24, stall=0.
REQ-025 RAW split: first even writes RT=3, second odd reads RA=3 -> issues in two cycles, even first, odd_pc=pc+4 second.
REQ-026 Flush in SPLIT: flush=1 with held instruction -> next cycle both valids 0, state ISSUE, held never appears.
REQ-027 Stop: first=add, second=0x00000000 -> add issues, halted=1 next cycle, stall stays 1 thereafter.
REQ-028 pipe_stall for 3 cycles after a dual issue -> outputs unchanged for 3 cycles, stall=1 throughout.

Source files
------------

// File: rtl/issue_stage.sv
// Dual-pipe issue stage: steers a fetched instruction pair onto the even/odd pipes,
// splitting the pair over two cycles on a structural or RAW conflict and halting on STOP.
module issue_stage #(
    parameter logic [0:31] EVEN_NOP = 32'h40200000,
    parameter logic [0:31] ODD_NOP  = 32'h00200000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic [0:31] pc_input,
    input  logic [0:31] first_inst,
    input  logic [0:31] second_inst,
    input  logic        pipe_stall,
    input  logic        flush,
    output logic        stall,
    output logic        even_valid,
    output logic        odd_valid,
    output logic [0:31] even_inst,
    output logic [0:31] odd_inst,
    output logic [0:31] even_pc,
    output logic [0:31] odd_pc,
    output logic        halted
);

    typedef enum logic [1:0] {ISSUE, SPLIT, HALT} state_t;

    state_t      state;
    logic [0:31] hold_inst_p1;
    logic [0:31] hold_pc_p1;

    state_t      n_state;
    logic [0:31] n_hold_inst;
    logic [0:31] n_hold_pc;
    logic        n_even_valid;
    logic        n_odd_valid;
    logic [0:31] n_even_inst;
    logic [0:31] n_odd_inst;
    logic [0:31] n_even_pc;
    logic [0:31] n_odd_pc;
    logic        n_halted;
    logic [0:31] second_pc;
    logic        pair_hazard;
    logic        split_pair;

    function automatic logic is_stop(input logic [0:31] inst);
        return inst[0:10] == 11'b0;
    endfunction

    function automatic logic is_odd(input logic [0:31] inst);
        return (inst[0:1] == 2'b00) && !is_stop(inst);
    endfunction

    function automatic logic writes_rt(input logic [0:31] inst);
        return !((inst[0:10] == EVEN_NOP[0:10]) || (inst[0:10] == ODD_NOP[0:10]));
    endfunction

    assign second_pc   = pc_input + 32'd4;
    assign pair_hazard = writes_rt(first_inst) &&
                         ((second_inst[18:24] == first_inst[25:31]) ||
                          (second_inst[11:17] == first_inst[25:31]));
    assign split_pair  = (is_odd(first_inst) == is_odd(second_inst)) || pair_hazard;

    assign stall = (state == SPLIT) || (state == HALT) || pipe_stall;

    always_comb begin
        n_state      = state;
        n_hold_inst  = hold_inst_p1;
        n_hold_pc    = hold_pc_p1;
        n_even_valid = 1'b0;
        n_odd_valid  = 1'b0;
        n_even_inst  = EVEN_NOP;
        n_odd_inst   = ODD_NOP;
        n_even_pc    = '0;
        n_odd_pc     = '0;
        n_halted     = (state == HALT);

        if (flush) begin
            // Redirect drops everything in flight, but a halted core stays halted.
            if (state != HALT) n_state = ISSUE;
            n_hold_inst = '0;
            n_hold_pc   = '0;
        end else if (pipe_stall) begin
            n_even_valid = even_valid;
            n_odd_valid  = odd_valid;
            n_even_inst  = even_inst;
            n_odd_inst   = odd_inst;
            n_even_pc    = even_pc;
            n_odd_pc     = odd_pc;
        end else begin
            case (state)
                ISSUE: begin
                    if (inst_valid) begin
                        if (is_stop(first_inst)) begin
                            n_state  = HALT;
                            n_halted = 1'b1;
                        end else begin
                            if (is_odd(first_inst)) begin
                                n_odd_valid = 1'b1;
                                n_odd_inst  = first_inst;
                                n_odd_pc    = pc_input;
                            end else begin
                                n_even_valid = 1'b1;
                                n_even_inst  = first_inst;
                                n_even_pc    = pc_input;
                            end
                            if (is_stop(second_inst)) begin
                                n_state  = HALT;
                                n_halted = 1'b1;
                            end else if (split_pair) begin
                                n_hold_inst = second_inst;
                                n_hold_pc   = second_pc;
                                n_state     = SPLIT;
                            end else if (is_odd(second_inst)) begin
                                n_odd_valid = 1'b1;
                                n_odd_inst  = second_inst;
                                n_odd_pc    = second_pc;
                            end else begin
                                n_even_valid = 1'b1;
                                n_even_inst  = second_inst;
                                n_even_pc    = second_pc;
                            end
                        end
                    end
                end
                SPLIT: begin
                    if (is_odd(hold_inst_p1)) begin
                        n_odd_valid = 1'b1;
                        n_odd_inst  = hold_inst_p1;
                        n_odd_pc    = hold_pc_p1;
                    end else begin
                        n_even_valid = 1'b1;
                        n_even_inst  = hold_inst_p1;
                        n_even_pc    = hold_pc_p1;
                    end
                    n_hold_inst = '0;
                    n_hold_pc   = '0;
                    n_state     = ISSUE;
                end
                HALT: begin
                    n_state = HALT;
                end
                default: begin
                    n_state = ISSUE;
                end
            endcase
        end
    end

    // Issue register stage: pipe outputs, hold register and state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ISSUE;
            hold_inst_p1 <= '0;
            hold_pc_p1   <= '0;
            even_valid   <= 1'b0;
            odd_valid    <= 1'b0;
            even_inst    <= EVEN_NOP;
            odd_inst     <= ODD_NOP;
            even_pc      <= '0;
            odd_pc       <= '0;
            halted       <= 1'b0;
        end else begin
            state        <= n_state;
            hold_inst_p1 <= n_hold_inst;
            hold_pc_p1   <= n_hold_pc;
            even_valid   <= n_even_valid;
            odd_valid    <= n_odd_valid;
            even_inst    <= n_even_inst;
            odd_inst     <= n_odd_inst;
            even_pc      <= n_even_pc;
            odd_pc       <= n_odd_pc;
            halted       <= n_halted;
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: dual issue, split, flush, stall, reset and STOP handling.
module tb_issue_stage;

    localparam logic [31:0] EVEN_NOP = 32'h40200000;
    localparam logic [31:0] ODD_NOP  = 32'h00200000;
    localparam logic [10:0] ADD_OP   = 11'b01100000000;
    localparam logic [10:0] LQD_OP   = 11'b00110100000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_valid = 1'b0;
    logic [0:31] pc_input = '0;
    logic [0:31] first_inst = '0;
    logic [0:31] second_inst = '0;
    logic        pipe_stall = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        even_valid, odd_valid;
    logic [0:31] even_inst, odd_inst, even_pc, odd_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    issue_stage dut (
        .clock      (clock),
        .reset      (reset),
        .inst_valid (inst_valid),
        .pc_input   (pc_input),
        .first_inst (first_inst),
        .second_inst(second_inst),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .stall      (stall),
        .even_valid (even_valid),
        .odd_valid  (odd_valid),
        .even_inst  (even_inst),
        .odd_inst   (odd_inst),
        .even_pc    (even_pc),
        .odd_pc     (odd_pc),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [10:0] op, input logic [6:0] rb,
                                       input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] f,
                         input logic [31:0] s);
        inst_valid  = v;
        pc_input    = pc;
        first_inst  = f;
        second_inst = s;
    endtask

    logic [31:0] a_dual, l_dual, a_s1, a_s2, a_raw, l_raw, l_nop;

    initial begin
        a_dual = mk(ADD_OP, 7'd1, 7'd2, 7'd5);
        l_dual = mk(LQD_OP, 7'd6, 7'd7, 7'd9);
        a_s1   = mk(ADD_OP, 7'd1, 7'd2, 7'd10);
        a_s2   = mk(ADD_OP, 7'd3, 7'd4, 7'd11);
        a_raw  = mk(ADD_OP, 7'd1, 7'd2, 7'd3);
        l_raw  = mk(LQD_OP, 7'd8, 7'd3, 7'd12);
        l_nop  = mk(LQD_OP, 7'd1, 7'd0, 7'd2);

        // Reset state
        #12;
        chk("rst_even_valid", {31'b0, even_valid}, 32'd0);
        chk("rst_odd_valid", {31'b0, odd_valid}, 32'd0);
        chk("rst_even_inst", even_inst, EVEN_NOP);
        chk("rst_odd_inst", odd_inst, ODD_NOP);
        chk("rst_even_pc", even_pc, 32'd0);
        chk("rst_odd_pc", odd_pc, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;

        // Dual issue
        drive(1'b1, 32'h10, a_dual, l_dual);
        step();
        chk("dual_even_valid", {31'b0, even_valid}, 32'd1);
        chk("dual_odd_valid", {31'b0, odd_valid}, 32'd1);
        chk("dual_even_pc", even_pc, 32'h10);
        chk("dual_odd_pc", odd_pc, 32'h14);
        chk("dual_even_inst", even_inst, a_dual);
        chk("dual_odd_inst", odd_inst, l_dual);
        chk("dual_stall", {31'b0, stall}, 32'd0);

        // Pipe stall freezes everything for 3 cycles
        pipe_stall = 1'b1;
        drive(1'b1, 32'h20, a_s1, a_s2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pst_even_pc", even_pc, 32'h10);
            chk("pst_odd_pc", odd_pc, 32'h14);
            chk("pst_valids", {30'b0, even_valid, odd_valid}, 32'd3);
            chk("pst_stall", {31'b0, stall}, 32'd1);
        end
        pipe_stall = 1'b0;

        // Structural split: two evens
        step();
        chk("ss1_even_pc", even_pc, 32'h20);
        chk("ss1_even_inst", even_inst, a_s1);
        chk("ss1_valids", {30'b0, even_valid, odd_valid}, 32'd2);
        chk("ss1_stall", {31'b0, stall}, 32'd1);
        drive(1'b1, 32'h90, a_dual, l_dual);
        step();
        chk("ss2_even_pc", even_pc, 32'h24);
        chk("ss2_even_inst", even_inst, a_s2);
        chk("ss2_valids", {30'b0, even_valid, odd_valid}, 32'd2);
        chk("ss2_stall", {31'b0, stall}, 32'd0);

        // RAW split: even writes r3, odd reads r3
        drive(1'b1, 32'h40, a_raw, l_raw);
        step();
        chk("raw1_even_pc", even_pc, 32'h40);
        chk("raw1_valids", {30'b0, even_valid, odd_valid}, 32'd2);
        chk("raw1_stall", {31'b0, stall}, 32'd1);
        step();
        chk("raw2_odd_pc", odd_pc, 32'h44);
        chk("raw2_odd_inst", odd_inst, l_raw);
        chk("raw2_valids", {30'b0, even_valid, odd_valid}, 32'd1);
        chk("raw2_even_inst", even_inst, EVEN_NOP);
        chk("raw2_even_pc", even_pc, 32'd0);

        // Even NOP does not write, so no RAW against r0
        drive(1'b1, 32'h48, EVEN_NOP, l_nop);
        step();
        chk("nop_valids", {30'b0, even_valid, odd_valid}, 32'd3);
        chk("nop_odd_pc", odd_pc, 32'h4c);

        // No instruction presented
        drive(1'b0, 32'h48, EVEN_NOP, l_nop);
        step();
        chk("idle_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("idle_odd_inst", odd_inst, ODD_NOP);
        chk("idle_even_pc", even_pc, 32'd0);

        // Flush while a held instruction waits
        drive(1'b1, 32'h50, a_s1, a_s2);
        step();
        chk("fl1_even_pc", even_pc, 32'h50);
        chk("fl1_stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        step();
        chk("fl2_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("fl2_stall", {31'b0, stall}, 32'd0);
        flush = 1'b0;
        inst_valid = 1'b0;
        step();
        chk("fl3_valids", {30'b0, even_valid, odd_valid}, 32'd0);

        // Flush wins over pipe_stall
        drive(1'b1, 32'h10, a_dual, l_dual);
        step();
        chk("fps1_valids", {30'b0, even_valid, odd_valid}, 32'd3);
        flush = 1'b1;
        pipe_stall = 1'b1;
        step();
        chk("fps2_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("fps2_odd_pc", odd_pc, 32'd0);
        flush = 1'b0;
        pipe_stall = 1'b0;

        // Reset in the middle of a split
        drive(1'b1, 32'h70, a_s1, a_s2);
        step();
        chk("rs1_even_pc", even_pc, 32'h70);
        #2 reset = 1'b1;
        #1;
        chk("rs_async_valid", {31'b0, even_valid}, 32'd0);
        chk("rs_async_inst", even_inst, EVEN_NOP);
        chk("rs_async_stall", {31'b0, stall}, 32'd0);
        reset = 1'b0;
        inst_valid = 1'b0;
        step();
        chk("rs2_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("rs2_stall", {31'b0, stall}, 32'd0);

        // STOP as second: first issues, then halt
        drive(1'b1, 32'h60, a_dual, 32'h0);
        step();
        chk("stop_even_valid", {31'b0, even_valid}, 32'd1);
        chk("stop_even_pc", even_pc, 32'h60);
        chk("stop_odd_valid", {31'b0, odd_valid}, 32'd0);
        chk("stop_halted", {31'b0, halted}, 32'd1);
        chk("stop_stall", {31'b0, stall}, 32'd1);
        drive(1'b1, 32'h10, a_dual, l_dual);
        flush = 1'b1;
        step();
        chk("halt_fl_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("halt_fl_halted", {31'b0, halted}, 32'd1);
        chk("halt_fl_stall", {31'b0, stall}, 32'd1);
        flush = 1'b0;
        step();
        chk("halt_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_stall", {31'b0, stall}, 32'd1);

        // STOP as first: nothing issues
        reset = 1'b1;
        #2 reset = 1'b0;
        chk("rst2_halted", {31'b0, halted}, 32'd0);
        drive(1'b1, 32'h80, 32'h0, a_dual);
        step();
        chk("stop1_valids", {30'b0, even_valid, odd_valid}, 32'd0);
        chk("stop1_halted", {31'b0, halted}, 32'd1);
        chk("stop1_stall", {31'b0, stall}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
